// File: rtl/pc_pkg.sv
// Shared constants and enums for the program-counter unit and its return-address stack.
package pc_pkg;

  localparam int PC_INC = 4;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_RET,
    SEL_TRAP
  } pc_sel_e;

  typedef enum logic [1:0] {
    RAS_EMPTY,
    RAS_PARTIAL,
    RAS_FULL
  } ras_state_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a simultaneous push and pop replaces the top entry in place.
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, topIdx;
  logic [CW-1:0]    count_q, count_d;
  ras_state_e       state_q, state_d;
  logic             doPop;

  // The pointer names the next free slot, so the top entry sits one below it.
  assign topIdx = ptr_q - PW'(1);
  assign doPop  = pop && (state_q != RAS_EMPTY);
  assign top    = mem_q[topIdx];
  assign empty  = (state_q == RAS_EMPTY);
  assign full   = (state_q == RAS_FULL);

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    state_d = state_q;
    if (push && !doPop) begin
      ptr_d = ptr_q + PW'(1);
      case (state_q)
        RAS_EMPTY: begin
          count_d = count_q + CW'(1);
          state_d = RAS_PARTIAL;
        end
        RAS_PARTIAL: begin
          count_d = count_q + CW'(1);
          if (count_q == CW'(DEPTH - 1)) state_d = RAS_FULL;
        end
        default: ;
      endcase
    end else if (doPop && !push) begin
      ptr_d   = ptr_q - PW'(1);
      count_d = count_q - CW'(1);
      case (state_q)
        RAS_FULL:    state_d = RAS_PARTIAL;
        RAS_PARTIAL: if (count_q == CW'(1)) state_d = RAS_EMPTY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q   <= '0;
      count_q <= '0;
      state_q <= RAS_EMPTY;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      state_q <= state_d;
      if (push) begin
        if (doPop) mem_q[topIdx] <= push_data;
        else       mem_q[ptr_q]  <= push_data;
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC selection, stall hold and return-address prediction.
// Define PC_MISALIGN_TRAP_EN to redirect misaligned targets to TRAP_VEC and flag misalign.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = 4
`ifdef PC_MISALIGN_TRAP_EN
  ,
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(32'h0000_0080)
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             link,
  input  logic             ret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             ras_empty,
`ifdef PC_MISALIGN_TRAP_EN
  output logic             misalign,
`endif
  output logic             ras_full
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] rasTop, target;
  logic             rasPush, rasPop, retOk;
  pc_sel_e          sel;

  assign pc_out   = pc_q;
  assign pc_plus4 = pc_q + WIDTH'(PC_INC);
  assign retOk    = ret && !ras_empty;
  assign rasPush  = !stall && jmp && link;
  assign rasPop   = !stall && retOk;

  pc_ras #(
    .WIDTH(WIDTH),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (rasPush),
    .pop      (rasPop),
    .push_data(pc_plus4),
    .top      (rasTop),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  // A return on an empty stack drops through to the jump/branch/sequential levels.
  always_comb begin
    sel    = SEL_SEQ;
    target = rasTop;
    if (retOk) begin
      sel    = SEL_RET;
      target = rasTop;
    end else if (jmp) begin
      sel    = SEL_JMP;
      target = jmp_target;
    end else if (br_taken) begin
      sel    = SEL_BR;
      target = br_target;
    end
`ifdef PC_MISALIGN_TRAP_EN
    if (sel != SEL_SEQ && target[1:0] != 2'b00) sel = SEL_TRAP;
`endif
    case (sel)
      SEL_SEQ:  pc_d = pc_plus4;
`ifdef PC_MISALIGN_TRAP_EN
      SEL_TRAP: pc_d = TRAP_VEC;
`endif
      default:  pc_d = target & ~WIDTH'(3);
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (!reset)      misalign_q <= 1'b0;
    else if (!stall) misalign_q <= (sel == SEL_TRAP);
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset)      pc_q <= RESET_VEC;
    else if (!stall) pc_q <= pc_d;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized checks of pc_unit against a queue-based reference model.
// Honours PC_MISALIGN_TRAP_EN the same way the design does.
module tb_pc_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RVEC  = 32'h0000_0000;
  localparam logic [31:0] TVEC  = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, jmp, link, ret;
  logic [31:0] br_target, jmp_target;
  logic [31:0] pc_out, pc_plus4;
  logic        ras_empty, ras_full;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  logic [31:0] mPc;
  logic [31:0] mRas[$];
  logic        mMis;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jmp       (jmp),
    .jmp_target(jmp_target),
    .link      (link),
    .ret       (ret),
    .pc_out    (pc_out),
    .pc_plus4  (pc_plus4),
    .ras_empty (ras_empty),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign  (misalign),
`endif
    .ras_full  (ras_full)
  );

  // Reference: the stack is a bounded queue whose back is the top entry.
  task automatic modelStep(input bit rstN, input bit st, input bit br, input logic [31:0] bt,
                           input bit j, input logic [31:0] jt, input bit l, input bit r);
    logic [31:0] plus4, tgt, dropped;
    bit retOk, hasT;
    if (!rstN) begin
      mPc = RVEC;
      mRas.delete();
      mMis = 1'b0;
    end else if (!st) begin
      plus4 = mPc + 32'd4;
      retOk = r && (mRas.size() > 0);
      hasT  = 1'b1;
      tgt   = 32'h0;
      if (retOk)   tgt = mRas[mRas.size()-1];
      else if (j)  tgt = jt;
      else if (br) tgt = bt;
      else         hasT = 1'b0;
      if (retOk && j && l) mRas[mRas.size()-1] = plus4;
      else if (retOk) dropped = mRas.pop_back();
      else if (j && l) begin
        mRas.push_back(plus4);
        if (mRas.size() > DEPTH) dropped = mRas.pop_front();
      end
      mMis = 1'b0;
      if (!hasT) mPc = plus4;
      else begin
`ifdef PC_MISALIGN_TRAP_EN
        if (tgt[1:0] != 2'b00) begin
          mPc  = TVEC;
          mMis = 1'b1;
        end else mPc = tgt;
`else
        mPc = {tgt[31:2], 2'b00};
`endif
      end
    end
  endtask

  task automatic checkOutput();
    testsRun += 4;
    assert (pc_out === mPc) else begin
      testsFailed++;
      $error("FAIL pc_out observed=%h expected=%h", pc_out, mPc);
    end
    assert (pc_plus4 === mPc + 32'd4) else begin
      testsFailed++;
      $error("FAIL pc_plus4 observed=%h expected=%h", pc_plus4, mPc + 32'd4);
    end
    assert (ras_empty === (mRas.size() == 0)) else begin
      testsFailed++;
      $error("FAIL ras_empty observed=%b expected=%b", ras_empty, mRas.size() == 0);
    end
    assert (ras_full === (mRas.size() == DEPTH)) else begin
      testsFailed++;
      $error("FAIL ras_full observed=%b expected=%b", ras_full, mRas.size() == DEPTH);
    end
`ifdef PC_MISALIGN_TRAP_EN
    testsRun++;
    assert (misalign === mMis) else begin
      testsFailed++;
      $error("FAIL misalign observed=%b expected=%b", misalign, mMis);
    end
`endif
  endtask

  task automatic applyStimulus(input bit rstN, input bit st, input bit br, input logic [31:0] bt,
                               input bit j, input logic [31:0] jt, input bit l, input bit r);
    reset = rstN; stall = st; br_taken = br; br_target = bt;
    jmp = j; jmp_target = jt; link = l; ret = r;
    modelStep(rstN, st, br, bt, j, jt, l, r);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic expectPc(input logic [31:0] want, input string tag);
    testsRun++;
    assert (pc_out === want) else begin
      testsFailed++;
      $error("FAIL %s observed=%h expected=%h", tag, pc_out, want);
    end
  endtask

  initial begin
    logic [31:0] bt, jt;
    mPc = RVEC;
    mMis = 1'b0;

    applyStimulus(0, 0, 0, 0, 1, 32'h40, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h40, 0, 0);
    expectPc(32'h0, "reset_pc");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    expectPc(32'h4, "first_seq");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    expectPc(32'h8, "second_seq");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    expectPc(32'h10, "reach_10");

    applyStimulus(1, 0, 1, 32'h100, 1, 32'h200, 0, 0);
    expectPc(32'h200, "jmp_over_br");
    applyStimulus(1, 0, 1, 32'h300, 0, 0, 0, 1);
    expectPc(32'h300, "ret_empty_falls_to_br");

    applyStimulus(1, 0, 0, 0, 1, 32'h20, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 32'h400, 1, 0);
    expectPc(32'h400, "call");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    expectPc(32'h24, "return");

    applyStimulus(1, 0, 0, 0, 1, 32'h0, 0, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(1, 0, 0, 0, 1, 32'h100 * i, 1, 0);
    testsRun++;
    assert (ras_full === 1'b1) else begin
      testsFailed++;
      $error("FAIL overflow_full observed=%b expected=1", ras_full);
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
      expectPc(32'h404 - 32'h100 * k, "nested_ret");
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    expectPc(32'h108, "ret_after_drain");

    applyStimulus(1, 0, 0, 0, 1, 32'h700, 1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0, 1, 32'h600, 1, 0);
      expectPc(32'h700, "stall_hold");
    end
    applyStimulus(1, 0, 0, 0, 1, 32'h600, 0, 0);
    expectPc(32'h600, "after_stall");

    applyStimulus(1, 0, 0, 0, 1, 32'h402, 0, 0);
`ifdef PC_MISALIGN_TRAP_EN
    expectPc(TVEC, "misalign_trap");
`else
    expectPc(32'h400, "misalign_mask");
`endif
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

    applyStimulus(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    expectPc(32'h0, "wrap");

    for (int n = 0; n < 400; n++) begin
      bt = $urandom;
      jt = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      applyStimulus($urandom_range(0, 31) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, bt, $urandom_range(0, 3) == 0, jt,
                    $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the single-cycle/pipelined MIPS-style core. It generalises the plain PC register with:
- next-PC selection (sequential, branch, jump, return)
- a stall hold
- a configurable return-address stack (RAS) that predicts return targets.

It sits at the front of the fetch path: its output drives instruction-memory address, and its inputs come from control and branch resolution.

Parameters:
WIDTH, 32, PC and target width in bits (≥8)
RESET_VEC, 32'h0000_0000, PC value loaded on reset
RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥2)
TRAP_VEC, 32'h0000_0080, redirect address on misaligned target (used only with PC_MISALIGN_TRAP_EN)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
stall  in  1  hold PC and RAS this cycle
br_taken  in  1  conditional branch resolved taken
br_target  in  WIDTH  branch target
jmp  in  1  unconditional jump
jmp_target  in  WIDTH  jump target
link  in  1  call (jal): push pc_plus4 onto RAS; qualified by jmp
ret  in  1  return (jr $ra): next PC taken from RAS top
pc_out  out  WIDTH  current PC (registered)
pc_plus4  out  WIDTH  pc_out + 4, combinational, wraps modulo 2^WIDTH
ras_empty  out  1  RAS count == 0
ras_full  out  1  RAS count == RAS_DEPTH
misalign  out  1  registered trap flag (present only with PC_MISALIGN_TRAP_EN)

Behaviour:
- Reset (reset==0 at rising edge):
  - pc_out=RESET_VEC
  - RAS pointer=0, count=0, entries=0
  - misalign=0
  - reset dominates stall and all requests.
- Latency:
  - pc_out updates one clock after the request.
  - pc_plus4, ras_empty and ras_full reflect current state combinationally.
- stall=1: pc_out, RAS contents, pointer and count all hold; all requests are ignored that cycle.
- Next-PC priority when not stalled: ret > jmp > br_taken > sequential (pc_plus4).
  - ret with RAS non-empty: next=top entry, pop (pointer--, count--).
  - ret with RAS empty: falls through to the next priority level; no pop.
  - jmp: next=jmp_target; if link=1, push pc_plus4.
  - link without jmp is ignored.
- Simultaneous ret and jmp&link:
  - next=old top.
  - top entry is overwritten with pc_plus4.
  - pointer and count unchanged.
- Push when full: circular overwrite of the oldest entry; pointer advances; count stays at RAS_DEPTH.
- Pointer arithmetic is modulo RAS_DEPTH.
- Targets with bits[1:0]!=0: bits[1:0] are forced to 0 before loading (default build).
- PC wrap-around: all-ones-aligned PC + 4 wraps to 0 with no flag.
- Sub-module pc_ras states: EMPTY (count=0), PARTIAL, FULL (count=RAS_DEPTH).
  - push: EMPTY→PARTIAL→FULL
  - pop: FULL→PARTIAL→EMPTY
  - push in FULL stays FULL.

Optional Feature:
PC_MISALIGN_TRAP_EN:
- Defined:
  - If the selected target (branch/jump/ret) has bits[1:0]!=0, next PC=TRAP_VEC and misalign=1 for exactly one cycle.
  - The RAS push/pop for that request still occurs.
  - Trap takes priority over alignment masking.
  - misalign is held during stall and cleared by reset.
- Undefined: misalign port absent; low bits are masked as described above.

Decomposition:
- Package pc_pkg holds:
  - PC_INC=4
  - next-PC select enum {SEL_SEQ, SEL_BR, SEL_JMP, SEL_RET, SEL_TRAP}
  - RAS state enum {RAS_EMPTY, RAS_PARTIAL, RAS_FULL}
- Natural sub-module: pc_ras, which holds RAS storage, pointer and count. Interface: push, pop, push_data; outputs top, empty, full.
- The next-PC mux and the PC register stay in pc_unit.

Test Plan:
- Reset: drive reset=0 with jmp=1, jmp_target=0x40 → pc_out=0x0, ras_empty=1. Release reset → pc_out=0x4, then 0x8.
- Priority: pc=0x10, br_taken=1 (br_target=0x100) and jmp=1 (jmp_target=0x200) in the same cycle → pc_out=0x200. Then ret on empty RAS with br_taken=1, br_target=0x300 → pc_out=0x300.
- Call/return: at pc=0x20 apply jmp&link to 0x400 → pc_out=0x400. Then ret → pc_out=0x24, ras_empty=1.
- Overflow: 5 nested calls from pcs 0x0,0x100,0x200,0x300,0x400 (each targeting the next) with RAS_DEPTH=4 → ras_full=1. Four rets yield 0x404, 0x304, 0x204, 0x104. The fifth ret falls through to sequential.
- Stall: stall=1 for 3 cycles with jmp=1 → pc_out constant and RAS count unchanged. Deassert stall with jmp still high → jump taken next edge.
- Misalign (macro on): jmp_target=0x402 → pc_out=TRAP_VEC 0x80, misalign=1 for one cycle. Macro off → pc_out=0x400.
